// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline control blocks.
package mips_pkg;

   // Mult/div sequencer state encoding
   typedef enum logic {
      RUN     = 1'b0,
      MD_WAIT = 1'b1
   } md_state_e;

   // Architectural register $zero; never a real hazard source
   localparam logic [4:0] REG_ZERO = 5'd0;

   // Width of the mult/div remaining-cycle counter
   localparam int unsigned MD_CNT_W = 6;

endpackage : mips_pkg

// File: rtl/hazard_control_unit_md_sequencer.sv
// Multi-cycle mult/div sequencer: tracks whether the unit is executing and
// how many cycles remain.
module md_sequencer
   import mips_pkg::*;
#(
   parameter int unsigned MD_CYCLES = 8
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                start_i,
   output logic                busy_o,
   output logic [MD_CNT_W-1:0] count_o
);

   localparam logic [MD_CNT_W-1:0] COUNT_LOAD = MD_CNT_W'(MD_CYCLES - 1);

   md_state_e             state_q;
   logic [MD_CNT_W-1:0]   count_q;
   logic                  busy_q;

   // State, remaining-cycle counter and busy flag updated together
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= RUN;
         count_q <= '0;
         busy_q  <= 1'b0;
      end else begin
         case (state_q)
            RUN: begin
               if (start_i) begin
                  state_q <= MD_WAIT;
                  count_q <= COUNT_LOAD;
                  busy_q  <= 1'b1;
               end
            end
            MD_WAIT: begin
               if (count_q == '0) begin
                  state_q <= RUN;
                  busy_q  <= 1'b0;
               end else begin
                  count_q <= count_q - 1'b1;
               end
            end
            default: begin
               state_q <= RUN;
               count_q <= '0;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign busy_o  = busy_q;
   assign count_o = count_q;

   // A new start while executing is dropped by the FSM; flag it in simulation
   ap_no_restart : assert property (@(posedge clk) disable iff (reset)
                                    !(start_i && (state_q == MD_WAIT)))
      else $error("md_sequencer: EX_MulDiv_Start while unit busy is ignored");

   initial begin
      assert (MD_CYCLES >= 2 && MD_CYCLES <= 64)
         else $error("md_sequencer: MD_CYCLES out of range 2..64");
   end

endmodule : md_sequencer

// File: rtl/hazard_control_unit.sv
// Pipeline hazard controller: load-use and HI/LO stalls, branch/jump flush,
// mult/div sequencing and a saturating stall-cycle counter.
module hazard_control_unit
   import mips_pkg::*;
#(
   parameter int unsigned MD_CYCLES = 8,
   parameter int unsigned PERF_W    = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [4:0]        ID_rs,
   input  logic [4:0]        ID_rt,
   input  logic              ID_UsesRt,
   input  logic              ID_Branch_Taken,
   input  logic              ID_Jump,
   input  logic              ID_Reads_HiLo,
   input  logic              ID_MulDiv,
   input  logic              EX_MemRead,
   input  logic [4:0]        EX_rt,
   input  logic              EX_MulDiv_Start,
   output logic              PCWrite,
   output logic              IFIDWrite,
   output logic              FLUSH,
   output logic              IDEX_Bubble,
   output logic              MD_Busy,
   output logic [5:0]        MD_Count,
   output logic [PERF_W-1:0] Stall_Count
);

   logic              load_use;
   logic              md_hazard;
   logic              stall;
   logic [PERF_W-1:0] stall_cnt_q;
   logic [PERF_W-1:0] stall_cnt_d;

   md_sequencer #(
      .MD_CYCLES (MD_CYCLES)
   ) u_md_seq (
      .clk     (clk),
      .reset   (reset),
      .start_i (EX_MulDiv_Start),
      .busy_o  (MD_Busy),
      .count_o (MD_Count)
   );

   assign load_use  = EX_MemRead & (EX_rt != REG_ZERO) &
                      ((EX_rt == ID_rs) | (ID_UsesRt & (EX_rt == ID_rt)));
   assign md_hazard = (ID_Reads_HiLo | ID_MulDiv) & (MD_Busy | EX_MulDiv_Start);
   assign stall     = load_use | md_hazard;

   // Hazard controls; reset forces them inactive, stall beats flush
   always_comb begin
      PCWrite     = ~reset & stall;
      IFIDWrite   = ~reset & stall;
      IDEX_Bubble = ~reset & stall;
      FLUSH       = ~reset & (ID_Branch_Taken | ID_Jump) & ~stall;
   end

   // Next stall count: one per stall cycle, held at all ones
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (stall && (stall_cnt_q != '1)) begin
         stall_cnt_d = stall_cnt_q + 1'b1;
      end
   end

   // Stall performance counter register
   always_ff @(posedge clk) begin
      if (reset) begin
         stall_cnt_q <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign Stall_Count = stall_cnt_q;

endmodule : hazard_control_unit

// File: tb/tb_hazard_control_unit.sv
// Self-checking bench for hazard_control_unit with a cycle-level reference model.
module tb_hazard_control_unit;

   localparam int MDC = 8;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [4:0] rs = '0, rt = '0, ex_rt = '0;
   logic       uses_rt = 1'b0, br = 1'b0, jmp = 1'b0, rdhl = 1'b0, idmd = 1'b0;
   logic       memrd = 1'b0, start = 1'b0;

   logic        pcw, ifw, fl, bub, busy;
   logic [5:0]  mdcnt;
   logic [15:0] scnt;
   logic        pcw4, ifw4, fl4, bub4, busy4;
   logic [5:0]  mdcnt4;
   logic [3:0]  scnt4;

   int n_pass = 0;
   int n_total = 0;

   // reference model state: cycles of busy left, total stall cycles since reset
   int m_left = 0;
   int m_total = 0;
   logic e_stall, e_flush, e_busy;
   int   e_mdcnt, e_scnt, e_scnt4;

   always #5 clk = ~clk;

   hazard_control_unit #(.MD_CYCLES(MDC), .PERF_W(16)) dut (
      .clk(clk), .reset(rst), .ID_rs(rs), .ID_rt(rt), .ID_UsesRt(uses_rt),
      .ID_Branch_Taken(br), .ID_Jump(jmp), .ID_Reads_HiLo(rdhl), .ID_MulDiv(idmd),
      .EX_MemRead(memrd), .EX_rt(ex_rt), .EX_MulDiv_Start(start),
      .PCWrite(pcw), .IFIDWrite(ifw), .FLUSH(fl), .IDEX_Bubble(bub),
      .MD_Busy(busy), .MD_Count(mdcnt), .Stall_Count(scnt));

   hazard_control_unit #(.MD_CYCLES(MDC), .PERF_W(4)) dut4 (
      .clk(clk), .reset(rst), .ID_rs(rs), .ID_rt(rt), .ID_UsesRt(uses_rt),
      .ID_Branch_Taken(br), .ID_Jump(jmp), .ID_Reads_HiLo(rdhl), .ID_MulDiv(idmd),
      .EX_MemRead(memrd), .EX_rt(ex_rt), .EX_MulDiv_Start(start),
      .PCWrite(pcw4), .IFIDWrite(ifw4), .FLUSH(fl4), .IDEX_Bubble(bub4),
      .MD_Busy(busy4), .MD_Count(mdcnt4), .Stall_Count(scnt4));

   task automatic clear_inputs();
      rst = 0; rs = 0; rt = 0; ex_rt = 0; uses_rt = 0; br = 0; jmp = 0;
      rdhl = 0; idmd = 0; memrd = 0; start = 0;
   endtask

   // expected outputs for the current inputs and model state
   task automatic settle();
      logic lu, mh;
      #1;
      lu = memrd && (ex_rt != 0) && ((ex_rt == rs) || (uses_rt && ex_rt == rt));
      mh = (rdhl || idmd) && (m_left > 0 || start);
      e_stall = (lu || mh) && !rst;
      e_flush = (br || jmp) && !(lu || mh) && !rst;
      e_busy  = (m_left > 0);
      e_mdcnt = e_busy ? m_left - 1 : 0;
      e_scnt  = (m_total > 65535) ? 65535 : m_total;
      e_scnt4 = (m_total > 15) ? 15 : m_total;
   endtask

   // model effect of the coming rising edge
   task automatic advance();
      if (rst) begin
         m_left = 0; m_total = 0;
      end else begin
         if (e_stall) m_total++;
         if (m_left > 0) m_left--;
         else if (start) m_left = MDC;
      end
   endtask

   task automatic do_reset();
      @(negedge clk); clear_inputs(); rst = 1; settle(); advance();
      @(negedge clk); clear_inputs(); settle(); advance();
   endtask

   task automatic test_reset();
      @(negedge clk); clear_inputs(); rst = 1;
      memrd = 1; ex_rt = 5; rs = 5; br = 1; rdhl = 1; start = 1; settle();
      n_total++;
      if ({pcw, ifw, fl, bub} !== 4'b0000)
         $display("FAIL reset_force_outputs got=%b want=0000", {pcw, ifw, fl, bub});
      else n_pass++;
      advance();
      @(negedge clk); clear_inputs(); settle();
      n_total++;
      if (busy !== 1'b0 || mdcnt !== 6'd0 || scnt !== 16'd0 || scnt4 !== 4'd0)
         $display("FAIL reset_state busy=%b mdcnt=%0d scnt=%0d scnt4=%0d want 0/0/0/0",
                  busy, mdcnt, scnt, scnt4);
      else n_pass++;
      advance();
   endtask

   task automatic test_load_use();
      do_reset();
      @(negedge clk); clear_inputs(); memrd = 1; ex_rt = 5; rs = 5; settle();
      n_total++;
      if ({pcw, ifw, bub, fl} !== 4'b1110)
         $display("FAIL load_use_stall got=%b want=1110", {pcw, ifw, bub, fl});
      else n_pass++;
      advance();
      @(negedge clk); clear_inputs(); rs = 5; settle();
      n_total++;
      if (pcw !== 1'b0 || scnt !== 16'd1)
         $display("FAIL load_use_one_cycle pcw=%b scnt=%0d want 0/1", pcw, scnt);
      else n_pass++;
      advance();
      @(negedge clk); clear_inputs(); memrd = 1; ex_rt = 0; rs = 0; rt = 0; uses_rt = 1; settle();
      n_total++;
      if (pcw !== 1'b0 || bub !== 1'b0)
         $display("FAIL load_use_r0 pcw=%b bub=%b want 0/0", pcw, bub);
      else n_pass++;
      advance();
      @(negedge clk); clear_inputs(); memrd = 1; ex_rt = 9; rt = 9; uses_rt = 0; rs = 2; settle();
      n_total++;
      if (pcw !== 1'b0)
         $display("FAIL load_use_rt_unused pcw=%b want 0", pcw);
      else n_pass++;
      advance();
   endtask

   task automatic test_branch();
      do_reset();
      @(negedge clk); clear_inputs(); br = 1; settle();
      n_total++;
      if (fl !== 1'b1 || pcw !== 1'b0)
         $display("FAIL branch_flush fl=%b pcw=%b want 1/0", fl, pcw);
      else n_pass++;
      advance();
      @(negedge clk); clear_inputs(); jmp = 1; settle();
      n_total++;
      if (fl !== 1'b1 || scnt !== 16'd0)
         $display("FAIL jump_flush fl=%b scnt=%0d want 1/0", fl, scnt);
      else n_pass++;
      advance();
      @(negedge clk); clear_inputs(); br = 1; memrd = 1; ex_rt = 7; rt = 7; uses_rt = 1; rs = 3; settle();
      n_total++;
      if (fl !== 1'b0 || pcw !== 1'b1)
         $display("FAIL branch_vs_stall fl=%b pcw=%b want 0/1", fl, pcw);
      else n_pass++;
      advance();
      @(negedge clk); clear_inputs(); br = 1; rt = 7; uses_rt = 1; rs = 3; settle();
      n_total++;
      if (fl !== 1'b1 || pcw !== 1'b0)
         $display("FAIL branch_after_stall fl=%b pcw=%b want 1/0", fl, pcw);
      else n_pass++;
      advance();
   endtask

   task automatic test_muldiv();
      do_reset();
      for (int k = 0; k <= MDC + 1; k++) begin
         @(negedge clk); clear_inputs(); rdhl = 1; start = (k == 0); settle();
         n_total++;
         if (pcw !== (k <= MDC) || busy !== (k >= 1 && k <= MDC) ||
             (k >= 1 && k <= MDC && mdcnt !== 6'(MDC - k)))
            $display("FAIL muldiv_cycle%0d pcw=%b busy=%b mdcnt=%0d want %b/%b/%0d", k,
                     pcw, busy, mdcnt, (k <= MDC), (k >= 1 && k <= MDC), MDC - k);
         else n_pass++;
         n_total++;
         if (pcw !== e_stall || busy !== e_busy || int'(mdcnt) !== e_mdcnt || int'(scnt) !== e_scnt)
            $display("FAIL muldiv_model%0d pcw=%b busy=%b mdcnt=%0d scnt=%0d want %b/%b/%0d/%0d",
                     k, pcw, busy, mdcnt, scnt, e_stall, e_busy, e_mdcnt, e_scnt);
         else n_pass++;
         advance();
      end
      n_total++;
      if (scnt !== 16'(MDC + 1))
         $display("FAIL muldiv_stall_total scnt=%0d want %0d", scnt, MDC + 1);
      else n_pass++;
   endtask

   task automatic test_independent();
      do_reset();
      @(negedge clk); clear_inputs(); start = 1; settle(); advance();
      for (int k = 1; k <= 3; k++) begin
         @(negedge clk); clear_inputs(); rs = 5'(k); rt = 5'(k + 1); br = 0; settle();
         n_total++;
         if (pcw !== 1'b0 || busy !== 1'b1)
            $display("FAIL indep_during_md%0d pcw=%b busy=%b want 0/1", k, pcw, busy);
         else n_pass++;
         advance();
      end
      for (int k = 4; k <= MDC + 1; k++) begin
         @(negedge clk); clear_inputs(); idmd = 1; settle();
         n_total++;
         if (pcw !== (k <= MDC) || pcw !== e_stall)
            $display("FAIL second_mult%0d pcw=%b want %b", k, pcw, (k <= MDC));
         else n_pass++;
         advance();
      end
   endtask

   task automatic test_reset_mid();
      int guard;
      do_reset();
      @(negedge clk); clear_inputs(); start = 1; settle(); advance();
      guard = 0;
      while (m_left != 4 && guard < 100) begin
         @(negedge clk); clear_inputs(); settle(); advance(); guard++;
      end
      @(negedge clk); clear_inputs(); rst = 1; rdhl = 1; memrd = 1; ex_rt = 4; rs = 4; settle();
      n_total++;
      if (mdcnt !== 6'd3 || busy !== 1'b1 || pcw !== 1'b0 || bub !== 1'b0)
         $display("FAIL reset_mid_pre mdcnt=%0d busy=%b pcw=%b bub=%b want 3/1/0/0",
                  mdcnt, busy, pcw, bub);
      else n_pass++;
      advance();
      @(negedge clk); clear_inputs(); settle();
      n_total++;
      if (busy !== 1'b0 || mdcnt !== 6'd0 || scnt !== 16'd0)
         $display("FAIL reset_mid_post busy=%b mdcnt=%0d scnt=%0d want 0/0/0", busy, mdcnt, scnt);
      else n_pass++;
      advance();
   endtask

   task automatic test_saturation();
      do_reset();
      for (int k = 0; k < 20; k++) begin
         @(negedge clk); clear_inputs(); memrd = 1; ex_rt = 5; rs = 5; settle();
         n_total++;
         if (int'(scnt4) !== e_scnt4 || int'(scnt) !== e_scnt)
            $display("FAIL sat_step%0d scnt4=%0d scnt=%0d want %0d/%0d", k, scnt4, scnt, e_scnt4, e_scnt);
         else n_pass++;
         advance();
      end
      @(negedge clk); clear_inputs(); settle();
      n_total++;
      if (scnt4 !== 4'd15 || scnt !== 16'd20)
         $display("FAIL sat_final scnt4=%0d scnt=%0d want 15/20", scnt4, scnt);
      else n_pass++;
      advance();
   endtask

   task automatic test_random();
      do_reset();
      for (int k = 0; k < 400; k++) begin
         @(negedge clk);
         rst     = ($urandom_range(0, 59) == 0);
         rs      = 5'($urandom_range(0, 3));
         rt      = 5'($urandom_range(0, 3));
         ex_rt   = 5'($urandom_range(0, 3));
         uses_rt = 1'($urandom);
         memrd   = 1'($urandom);
         br      = ($urandom_range(0, 3) == 0);
         jmp     = ($urandom_range(0, 5) == 0);
         rdhl    = ($urandom_range(0, 3) == 0);
         idmd    = ($urandom_range(0, 5) == 0);
         start   = (m_left == 0) && ($urandom_range(0, 3) == 0);
         settle();
         n_total++;
         if (pcw !== e_stall || ifw !== e_stall || bub !== e_stall || fl !== e_flush ||
             busy !== e_busy || int'(mdcnt) !== e_mdcnt || int'(scnt) !== e_scnt ||
             int'(scnt4) !== e_scnt4)
            $display("FAIL random%0d pcw=%b ifw=%b bub=%b fl=%b busy=%b mdcnt=%0d scnt=%0d scnt4=%0d want stall=%b fl=%b busy=%b mdcnt=%0d scnt=%0d scnt4=%0d",
                     k, pcw, ifw, bub, fl, busy, mdcnt, scnt, scnt4,
                     e_stall, e_flush, e_busy, e_mdcnt, e_scnt, e_scnt4);
         else n_pass++;
         advance();
      end
   endtask

   initial begin
      clear_inputs();
      test_reset();
      test_load_use();
      test_branch();
      test_muldiv();
      test_independent();
      test_reset_mid();
      test_saturation();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout simulation did not finish");
      $fatal(1, "timeout");
   end

endmodule : tb_hazard_control_unit

// File: doc/hazard_control_unit.md
# hazard_control_unit

Pipeline hazard controller for the five-stage MIPS core. It sits beside the IF/ID and ID/EX pipeline registers and the PC and drives their hold, flush and bubble controls. It detects load-use hazards and taken branches/jumps resolved in ID. It also sequences a multi-cycle multiply/divide unit, stalling HI/LO consumers until the result is ready, and keeps a saturating stall-cycle performance counter.

## Interface
Parameters:
- MD_CYCLES, 8: execution cycles of the mult/div unit; legal range 2..64.
- PERF_W, 16: width of the stall performance counter.

Ports:
- clk  in  1  pipeline clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- ID_rs  in  5  rs field of the instruction in ID.
- ID_rt  in  5  rt field of the instruction in ID.
- ID_UsesRt  in  1  the ID instruction reads rt as a source.
- ID_Branch_Taken  in  1  branch in ID resolved taken.
- ID_Jump  in  1  jump in ID.
- ID_Reads_HiLo  in  1  mfhi/mflo in ID.
- ID_MulDiv  in  1  mult/div instruction in ID.
- EX_MemRead  in  1  load in EX.
- EX_rt  in  5  destination of the load in EX.
- EX_MulDiv_Start  in  1  mult/div in EX this cycle; starts the unit.
- PCWrite  out  1  1 = hold PC.
- IFIDWrite  out  1  1 = hold IF/ID. Same inverted sense as the existing IF/ID register.
- FLUSH  out  1  1 = clear IF/ID.
- IDEX_Bubble  out  1  1 = load zeros (nop) into ID/EX.
- MD_Busy  out  1  mult/div unit executing.
- MD_Count  out  6  remaining mult/div cycles minus one.
- Stall_Count  out  PERF_W  saturating count of stall cycles.

## Operation
- States: RUN, MD_WAIT.
  - RUN → MD_WAIT when EX_MulDiv_Start=1; MD_Count loads MD_CYCLES-1.
  - In MD_WAIT, MD_Count decrements each cycle. At MD_Count=0, the next state is RUN.
  - EX_MulDiv_Start while in MD_WAIT is ignored and flagged by a simulation assertion.
- load_use = EX_MemRead & (EX_rt≠0) & ((EX_rt==ID_rs) | (ID_UsesRt & EX_rt==ID_rt)).
- md_hazard = (ID_Reads_HiLo | ID_MulDiv) & (state==MD_WAIT | EX_MulDiv_Start).
- stall = load_use | md_hazard. When stall=1: PCWrite=1, IFIDWrite=1, IDEX_Bubble=1.
- FLUSH = (ID_Branch_Taken | ID_Jump) & ~stall. Stall has priority because the branch operands are not yet valid.
- MD_Busy = (state==MD_WAIT).
- Stall_Count increments on each cycle with stall=1 and saturates at all ones; it never wraps.
- All hazard outputs are combinational from the inputs and state. State and counters are registered.

## Timing
- Reset, sampled at a rising edge: state=RUN, MD_Count=0, Stall_Count=0. During any cycle with reset=1, PCWrite, IFIDWrite, FLUSH and IDEX_Bubble are forced to 0.
- Reset mid-operation aborts MD_WAIT; RUN is entered at the next edge.
- Load-use costs exactly one stall cycle: the load moves to MEM, so load_use drops the following cycle.
- Mult/div with EX_MulDiv_Start=1 in cycle N:
  - MD_Busy=1 in cycles N+1 .. N+MD_CYCLES.
  - MD_Count reads MD_CYCLES-1 in cycle N+1 and 0 in cycle N+MD_CYCLES.
  - RUN again at N+MD_CYCLES+1.
  - A HI/LO consumer in ID stalls from cycle N through N+MD_CYCLES and proceeds in N+MD_CYCLES+1.
- Load_use and md_hazard in the same cycle produce a single stall cycle, counted once.
- A taken branch alone gives FLUSH for one cycle, with zero stall.

## Structure
- Shared package mips_pkg: state encoding (RUN=0, MD_WAIT=1) and the register-zero constant.
- One natural sub-module: md_sequencer, holding the state register, MD_Count and MD_Busy.
- Hazard equations and Stall_Count stay in the top module.

## Test plan
- Load-use: EX_MemRead=1, EX_rt=5, ID_rs=5 → PCWrite=IFIDWrite=IDEX_Bubble=1 for one cycle, Stall_Count 0→1. With EX_rt=0 → no stall.
- Branch: ID_Branch_Taken=1, no hazard → FLUSH=1 for one cycle, no stall. Branch plus load-use on ID_rt with ID_UsesRt=1 → FLUSH=0 and stall=1, then FLUSH=1 in the next cycle.
- Mult/div with MD_CYCLES=8: start pulse at cycle 0, then mfhi in ID → stall cycles 0..8, MD_Busy cycles 1..8, MD_Count 7→0, and Stall_Count ends at 9.
- Independent instructions during MD_WAIT → no stall; a second mult in ID stalls until RUN.
- Reset asserted at MD_Count=3 → next cycle: RUN, MD_Busy=0, all counters 0.
- Saturation with PERF_W=4 → after 20 stall cycles Stall_Count=15.
